perf_mmio_monitor: RTL and testbench

//  Synthesizable successor to the bench-side simulation I/O map and prediction-statistics counters.
//  - Snoops the core's data-memory write port and decodes a BASE_ADDR window into:

---
 rtl/perf_mmio_monitor_pkg.sv | 28 ++
 rtl/pmon_counter.sv | 36 +++
 rtl/perf_mmio_monitor.sv | 160 ++++++++++++++++
 tb/tb_perf_mmio_monitor.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/perf_mmio_monitor_pkg.sv
// ============================================================================
// Module : perf_mmio_monitor_pkg
// Brief  : Address map, FSM encodings and a decode helper for the perf monitor
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package perf_mmio_monitor_pkg;

  localparam logic [5:0] PMON_OFF_CHAR   = 6'h00;
  localparam logic [5:0] PMON_OFF_INT    = 6'h04;
  localparam logic [5:0] PMON_OFF_FINISH = 6'h08;
  localparam logic [5:0] PMON_OFF_CTRL   = 6'h0C;
  localparam logic [5:0] PMON_OFF_CYCLE  = 6'h10;
  localparam logic [5:0] PMON_OFF_STATUS = 6'h14;
  localparam logic [5:0] PMON_OFF_EVT0   = 6'h20;

  localparam logic [1:0] PMON_ST_RUN    = 2'd0;
  localparam logic [1:0] PMON_ST_FROZEN = 2'd1;
  localparam logic [1:0] PMON_ST_HALTED = 2'd2;

  function automatic logic [5:0] pmon_evt_off(input int k);
    return PMON_OFF_EVT0 + 6'(4 * k);
  endfunction

endpackage

`default_nettype wire

// File: rtl/pmon_counter.sv
// ============================================================================
// Module : pmon_counter
// Brief  : Wrapping event counter with sticky overflow and synchronous clear
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module pmon_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] cnt,
  output logic             ovf
);

  // clr outranks a same-cycle increment, so that event is dropped
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
      ovf <= 1'b0;
    end else if (clr) begin
      cnt <= '0;
      ovf <= 1'b0;
    end else if (en && inc) begin
      cnt <= cnt + CNT_W'(1);
      if (&cnt) ovf <= 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/perf_mmio_monitor.sv
// ============================================================================
// Module : perf_mmio_monitor
// Brief  : Snoops data-memory stores for sim I/O and exposes perf counters
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module perf_mmio_monitor
  import perf_mmio_monitor_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0,
  parameter int          NUM_EVT   = 3,
  parameter int          CNT_W     = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_EVT-1:0] evt_i,
  input  logic               dmem_we,
  input  logic               dmem_re,
  input  logic [31:0]        dmem_addr,
  input  logic [31:0]        dmem_wdata,
  output logic [31:0]        rdata,
  output logic               rvalid,
  output logic               char_valid,
  output logic [7:0]         char_data,
  output logic               int_valid,
  output logic [31:0]        int_data,
  output logic               finish,
  output logic               halted
);

  logic [1:0]       r_state;
  logic             r_rvalid;
  logic [31:0]      r_rdata;
  logic             r_char_valid;
  logic [7:0]       r_char_data;
  logic             r_int_valid;
  logic [31:0]      r_int_data;
  logic             r_finish;

  logic             w_in_win;
  logic [5:0]       w_off;
  logic             w_st;
  logic             w_st_char;
  logic             w_st_int;
  logic             w_st_fin;
  logic             w_st_ctrl;
  logic             w_clr;
  logic             w_en;
  logic             w_rd;
  logic [31:0]      w_rmux;
  logic [NUM_EVT:0] w_inc;
  logic [NUM_EVT:0] w_ovf;
  logic [CNT_W-1:0] w_cnt [NUM_EVT+1];
  logic             w_unused_addr;

  assign w_in_win      = (dmem_addr[31:6] == BASE_ADDR[31:6]);
  assign w_off         = {dmem_addr[5:2], 2'b00};
  assign w_unused_addr = ^dmem_addr[1:0];

  // Once halted, every store is invisible, which also blocks a second finish
  assign w_st      = dmem_we && w_in_win && (r_state != PMON_ST_HALTED);
  assign w_st_char = w_st && (w_off == PMON_OFF_CHAR);
  assign w_st_int  = w_st && (w_off == PMON_OFF_INT);
  assign w_st_fin  = w_st && (w_off == PMON_OFF_FINISH);
  assign w_st_ctrl = w_st && (w_off == PMON_OFF_CTRL);
  assign w_clr     = w_st_ctrl && dmem_wdata[1];
  assign w_en      = (r_state == PMON_ST_RUN);
  assign w_rd      = dmem_re && w_in_win;

  // Slot 0 is the cycle counter; slot k+1 tracks evt_i[k]
  assign w_inc = {evt_i, 1'b1};

  generate
    for (genvar i = 0; i <= NUM_EVT; i++) begin : g_cnt
      pmon_counter #(
        .CNT_W (CNT_W)
      ) u_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (w_inc[i]),
        .clr   (w_clr),
        .en    (w_en),
        .cnt   (w_cnt[i]),
        .ovf   (w_ovf[i])
      );
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= PMON_ST_RUN;
    end else begin
      case (r_state)
        PMON_ST_RUN: begin
          if (w_st_fin)                        r_state <= PMON_ST_HALTED;
          else if (w_st_ctrl && !dmem_wdata[0]) r_state <= PMON_ST_FROZEN;
        end
        PMON_ST_FROZEN: begin
          if (w_st_fin)                       r_state <= PMON_ST_HALTED;
          else if (w_st_ctrl && dmem_wdata[0]) r_state <= PMON_ST_RUN;
        end
        PMON_ST_HALTED: r_state <= PMON_ST_HALTED;
        default:        r_state <= PMON_ST_RUN;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_char_valid <= 1'b0;
      r_char_data  <= '0;
      r_int_valid  <= 1'b0;
      r_int_data   <= '0;
      r_finish     <= 1'b0;
    end else begin
      r_char_valid <= w_st_char;
      r_int_valid  <= w_st_int;
      r_finish     <= w_st_fin;
      if (w_st_char) r_char_data <= dmem_wdata[7:0];
      if (w_st_int)  r_int_data  <= dmem_wdata;
    end
  end

  // Mux sees counters before this edge's update: reads return pre-update values
  always_comb begin
    w_rmux = '0;
    case (w_off)
      PMON_OFF_CYCLE:  w_rmux[CNT_W-1:0] = w_cnt[0];
      PMON_OFF_STATUS: w_rmux[NUM_EVT:0] = w_ovf;
      default: begin
        for (int k = 0; k < NUM_EVT; k++) begin
          if (w_off == pmon_evt_off(k)) w_rmux[CNT_W-1:0] = w_cnt[k+1];
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
    end else begin
      r_rvalid <= w_rd;
      if (w_rd) r_rdata <= w_rmux;
    end
  end

  assign rdata      = r_rdata;
  assign rvalid     = r_rvalid;
  assign char_valid = r_char_valid;
  assign char_data  = r_char_data;
  assign int_valid  = r_int_valid;
  assign int_data   = r_int_data;
  assign finish     = r_finish;
  assign halted     = (r_state == PMON_ST_HALTED);

endmodule

`default_nettype wire

// File: tb/tb_perf_mmio_monitor.sv
// ============================================================================
// Module : tb_perf_mmio_monitor
// Brief  : Scoreboard bench for perf_mmio_monitor (NUM_EVT=3, CNT_W=16)
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_perf_mmio_monitor;

  localparam logic [31:0] BASE = 32'h0000_1000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  evt_i = '0;
  logic        dmem_we = 1'b0;
  logic        dmem_re = 1'b0;
  logic [31:0] dmem_addr = '0;
  logic [31:0] dmem_wdata = '0;
  logic [31:0] rdata;
  logic        rvalid;
  logic        char_valid;
  logic [7:0]  char_data;
  logic        int_valid;
  logic [31:0] int_data;
  logic        finish;
  logic        halted;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] exp_q[$];
  logic [31:0] obs_q[$];
  logic [15:0] cyc_exp = '0;
  logic        cyc_ovf = 1'b0;
  bit          running = 1'b0;
  bit          halted_exp = 1'b0;

  perf_mmio_monitor #(
    .BASE_ADDR (BASE),
    .NUM_EVT   (3),
    .CNT_W     (16)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .evt_i      (evt_i),
    .dmem_we    (dmem_we),
    .dmem_re    (dmem_re),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .rdata      (rdata),
    .rvalid     (rvalid),
    .char_valid (char_valid),
    .char_data  (char_data),
    .int_valid  (int_valid),
    .int_data   (int_data),
    .finish     (finish),
    .halted     (halted)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (rvalid) obs_q.push_back(rdata);

  initial begin
    #5_000_000;
    $display("FAIL timeout: simulation did not reach its end");
    $fatal(1);
  end

  // Advances one clock; the bench's own cycle-counter model follows run state
  task automatic tick();
    @(posedge clk);
    if (running) begin
      if (cyc_exp == 16'hFFFF) cyc_ovf = 1'b1;
      cyc_exp = cyc_exp + 16'd1;
    end
    #1;
  endtask

  task automatic store(input logic [5:0] off, input logic [31:0] d);
    dmem_we    = 1'b1;
    dmem_addr  = BASE + {26'b0, off};
    dmem_wdata = d;
    tick();
    dmem_we = 1'b0;
    if (!halted_exp && off == 6'h0C) begin
      if (d[1]) begin
        cyc_exp = '0;
        cyc_ovf = 1'b0;
      end
      running = d[0];
    end
    if (!halted_exp && off == 6'h08) begin
      halted_exp = 1'b1;
      running    = 1'b0;
    end
  endtask

  task automatic load(input logic [31:0] addr, input logic [31:0] e, input bit resp);
    dmem_re   = 1'b1;
    dmem_addr = addr;
    if (resp) exp_q.push_back(e);
    tick();
    dmem_re = 1'b0;
  endtask

  task automatic drain(input string tag);
    logic [31:0] e;
    logic [31:0] o;
    tick();
    n_cmp++;
    if (obs_q.size() != exp_q.size()) begin
      n_err++;
      $display("FAIL %s read-count: got %0d responses, expected %0d", tag, obs_q.size(), exp_q.size());
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_cmp++;
      if (o !== e) begin
        n_err++;
        $display("FAIL %s rdata: got %0h expected %0h", tag, o, e);
      end
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    running = 1'b0;
    halted_exp = 1'b0;
    tick();
    tick();
    n_cmp++;
    if ({rvalid, char_valid, int_valid, finish, halted} !== 5'b0) begin
      n_err++;
      $display("FAIL reset_pulses: got %b expected 00000", {rvalid, char_valid, int_valid, finish, halted});
    end
    n_cmp++;
    if ({rdata, int_data, char_data} !== 72'h0) begin
      n_err++;
      $display("FAIL reset_data: got %0h expected 0", {rdata, int_data, char_data});
    end
    reset   = 1'b0;
    cyc_exp = '0;
    cyc_ovf = 1'b0;
    running = 1'b1;
    load(BASE + 32'h10, {16'b0, cyc_exp}, 1'b1);
    drain("reset_cycle");
  endtask

  task automatic test_char_int();
    store(6'h00, 32'hFFFF_FF41);
    n_cmp++;
    if ({char_valid, char_data, int_valid, finish} !== {1'b1, 8'h41, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL char_store: got v=%b d=%0h int=%b fin=%b expected v=1 d=41 int=0 fin=0",
               char_valid, char_data, int_valid, finish);
    end
    store(6'h04, 32'h1234_5678);
    n_cmp++;
    if ({char_valid, int_valid, int_data} !== {1'b0, 1'b1, 32'h1234_5678}) begin
      n_err++;
      $display("FAIL int_store1: got cv=%b iv=%b d=%0h expected cv=0 iv=1 d=12345678",
               char_valid, int_valid, int_data);
    end
    store(6'h04, 32'hDEAD_BEEF);
    n_cmp++;
    if ({int_valid, int_data} !== {1'b1, 32'hDEAD_BEEF}) begin
      n_err++;
      $display("FAIL int_store2: got iv=%b d=%0h expected iv=1 d=deadbeef", int_valid, int_data);
    end
    tick();
    n_cmp++;
    if ({char_valid, int_valid} !== 2'b00) begin
      n_err++;
      $display("FAIL pulse_end: got %b expected 00", {char_valid, int_valid});
    end
  endtask

  task automatic test_events();
    evt_i = 3'b001;
    repeat (10) tick();
    evt_i = 3'b010;
    repeat (3) tick();
    evt_i = 3'b000;
    load(BASE + 32'h20, 32'd10, 1'b1);
    load(BASE + 32'h24, 32'd3, 1'b1);
    load(BASE + 32'h28, 32'd0, 1'b1);
    load(BASE + 32'h14, 32'd0, 1'b1);
    load(BASE + 32'h18, 32'd0, 1'b1);
    load(BASE + 32'h40, 32'd0, 1'b0);
    load(BASE + 32'h23, 32'd10, 1'b1);
    load(BASE + 32'h10, {16'b0, cyc_exp}, 1'b1);
    drain("events");
  endtask

  task automatic test_wrap_clear();
    evt_i = 3'b100;
    repeat (65535) tick();
    evt_i = 3'b000;
    load(BASE + 32'h28, 32'd65535, 1'b1);
    load(BASE + 32'h14, {31'b0, cyc_ovf}, 1'b1);
    evt_i = 3'b100;
    tick();
    evt_i = 3'b000;
    load(BASE + 32'h28, 32'd0, 1'b1);
    load(BASE + 32'h14, {28'b0, 1'b1, 2'b00, cyc_ovf}, 1'b1);
    evt_i = 3'b001;
    store(6'h0C, 32'h2);
    evt_i = 3'b000;
    load(BASE + 32'h20, 32'd0, 1'b1);
    load(BASE + 32'h24, 32'd0, 1'b1);
    load(BASE + 32'h28, 32'd0, 1'b1);
    load(BASE + 32'h14, 32'd0, 1'b1);
    load(BASE + 32'h10, {16'b0, cyc_exp}, 1'b1);
    drain("wrap_clear");
  endtask

  task automatic test_freeze();
    store(6'h0C, 32'h0);
    evt_i = 3'b001;
    repeat (5) tick();
    evt_i = 3'b000;
    load(BASE + 32'h20, 32'd0, 1'b1);
    load(BASE + 32'h10, {16'b0, cyc_exp}, 1'b1);
    store(6'h00, 32'h5A);
    n_cmp++;
    if ({char_valid, char_data} !== {1'b1, 8'h5A}) begin
      n_err++;
      $display("FAIL frozen_char: got v=%b d=%0h expected v=1 d=5a", char_valid, char_data);
    end
    store(6'h0C, 32'h1);
    evt_i = 3'b001;
    repeat (5) tick();
    evt_i = 3'b000;
    load(BASE + 32'h20, 32'd5, 1'b1);
    load(BASE + 32'h10, {16'b0, cyc_exp}, 1'b1);
    drain("freeze");
  endtask

  task automatic test_finish();
    evt_i = 3'b001;
    store(6'h08, 32'h0);
    evt_i = 3'b000;
    n_cmp++;
    if ({finish, halted} !== 2'b11) begin
      n_err++;
      $display("FAIL finish_pulse: got fin=%b halt=%b expected 1 1", finish, halted);
    end
    tick();
    n_cmp++;
    if ({finish, halted} !== 2'b01) begin
      n_err++;
      $display("FAIL finish_end: got fin=%b halt=%b expected 0 1", finish, halted);
    end
    store(6'h08, 32'h0);
    store(6'h00, 32'h42);
    n_cmp++;
    if ({finish, char_valid} !== 2'b00) begin
      n_err++;
      $display("FAIL halted_stores: got fin=%b cv=%b expected 0 0", finish, char_valid);
    end
    store(6'h0C, 32'h3);
    evt_i = 3'b001;
    repeat (4) tick();
    evt_i = 3'b000;
    load(BASE + 32'h20, 32'd6, 1'b1);
    load(BASE + 32'h10, {16'b0, cyc_exp}, 1'b1);
    drain("finish");
  endtask

  task automatic test_reset_mid();
    reset      = 1'b1;
    halted_exp = 1'b0;
    running    = 1'b0;
    #1;
    n_cmp++;
    if ({halted, finish, rvalid, rdata} !== 35'h0) begin
      n_err++;
      $display("FAIL async_reset: got halt=%b fin=%b rv=%b rd=%0h expected all 0",
               halted, finish, rvalid, rdata);
    end
    tick();
    reset   = 1'b0;
    cyc_exp = '0;
    cyc_ovf = 1'b0;
    running = 1'b1;
    store(6'h00, 32'h43);
    reset   = 1'b1;
    running = 1'b0;
    #1;
    n_cmp++;
    if ({char_valid, char_data} !== 9'h0) begin
      n_err++;
      $display("FAIL reset_pending: got v=%b d=%0h expected 0 0", char_valid, char_data);
    end
    #1;
    reset   = 1'b0;
    cyc_exp = '0;
    running = 1'b1;
    evt_i = 3'b001;
    repeat (3) tick();
    evt_i = 3'b000;
    load(BASE + 32'h20, 32'd3, 1'b1);
    load(BASE + 32'h24, 32'd0, 1'b1);
    load(BASE + 32'h14, 32'd0, 1'b1);
    load(BASE + 32'h10, {16'b0, cyc_exp}, 1'b1);
    drain("reset_mid");
  endtask

  initial begin
    test_reset();
    test_char_int();
    test_events();
    test_wrap_clear();
    test_freeze();
    test_finish();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
